aes_host_bridge: RTL and testbench

- Host-side counterpart of the byte-serial AES core.
- Accepts a 128-bit block, a 128-bit key and an encrypt/decrypt flag over a valid/ready handshake, and serializes them into the core's byte stream with a start pulse.
- Collects the core's 16 indexed output bytes back into a 128-bit result, which it presents over a second valid/ready handshake.
- Sits between a bus/DMA front end and the AES core.

---
 rtl/aes_host_bridge_if.sv | 37 +++
 rtl/aes_host_bridge.sv | 165 ++++++++++++++++
 tb/tb_aes_host_bridge.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_host_bridge_if.sv
// aes_host_bridge_if: host request/result handshakes plus the byte-serial AES core link.
// Ports: none; signals only. slave = bridge side, master = host/front-end side.
//   req_* : 128-bit block/key/flag in (valid/ready); res_* : 128-bit result + error out (valid/ready)
//   core_* : byte stream, start and idle to the core; indexed result bytes back from the core
interface aes_host_bridge_if;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_data;
  logic [127:0] req_key;
  logic         req_encrypt;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic [1:0]   res_err;
  logic [7:0]   core_data;
  logic [7:0]   core_key;
  logic         core_start;
  logic         core_encrypt;
  logic         core_idle;
  logic         core_out_valid;
  logic [3:0]   core_out_byte_num;
  logic [7:0]   core_data_out;

  modport slave (
    input  req_valid, req_data, req_key, req_encrypt, res_ready,
    input  core_out_valid, core_out_byte_num, core_data_out,
    output req_ready, res_valid, res_data, res_err,
    output core_data, core_key, core_start, core_encrypt, core_idle
  );

  modport master (
    output req_valid, req_data, req_key, req_encrypt, res_ready,
    output core_out_valid, core_out_byte_num, core_data_out,
    input  req_ready, res_valid, res_data, res_err,
    input  core_data, core_key, core_start, core_encrypt, core_idle
  );
endinterface

// File: rtl/aes_host_bridge.sv
// aes_host_bridge: serializes a 128-bit block/key into the byte-serial AES core (16 cycles,
// start on byte 0) and gathers the 16 indexed result bytes into a 128-bit result.
// Ports: clk, rst (sync, active-low), bus (aes_host_bridge_if.slave). All outputs registered.
// Latency: accept at edge T -> byte 0 + start in cycle T+1, byte 15 in T+16, WAIT from T+17;
//   index-15 byte captured at edge C -> res_valid from C+1. One job in flight; req_ready low until
//   the result is taken.
// Optional: define AES_HOST_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES idle cycles (res_err[1]).
module aes_host_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              rst,
  aes_host_bridge_if.slave bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("aes_host_bridge: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t       r_state;
  logic [127:0] r_blk;        // remaining block bytes, next byte always at [127:120]
  logic [127:0] r_key;        // remaining key bytes, same layout
  logic [3:0]   r_k;          // index of the byte currently on core_data/core_key
  logic [3:0]   r_exp;        // next in-order result index expected
  logic [127:0] r_res;
  logic         r_err_ooo;
  logic         r_req_ready;
  logic         r_res_valid;
  logic [7:0]   r_core_data;
  logic [7:0]   r_core_key;
  logic         r_core_start;
  logic         r_core_encrypt;
  logic         r_core_idle;
  logic         w_err_to;

`ifdef AES_HOST_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] r_to_cnt;
  logic        r_err_to;
  assign w_err_to = r_err_to;
`else
  assign w_err_to = 1'b0;
`endif

  assign bus.req_ready    = r_req_ready;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_data     = r_res;
  assign bus.res_err      = {w_err_to, r_err_ooo};
  assign bus.core_data    = r_core_data;
  assign bus.core_key     = r_core_key;
  assign bus.core_start   = r_core_start;
  assign bus.core_encrypt = r_core_encrypt;
  assign bus.core_idle    = r_core_idle;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_blk          <= '0;
      r_key          <= '0;
      r_k            <= '0;
      r_exp          <= '0;
      r_res          <= '0;
      r_err_ooo      <= 1'b0;
      r_req_ready    <= 1'b1;
      r_res_valid    <= 1'b0;
      r_core_data    <= '0;
      r_core_key     <= '0;
      r_core_start   <= 1'b0;
      r_core_encrypt <= 1'b0;
      r_core_idle    <= 1'b1;
`ifdef AES_HOST_TIMEOUT_EN
      r_to_cnt       <= '0;
      r_err_to       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            // Byte 0 goes straight to the output registers; the rest queue up in the shifters.
            r_core_data    <= bus.req_data[127:120];
            r_core_key     <= bus.req_key[127:120];
            r_blk          <= {bus.req_data[119:0], 8'h00};
            r_key          <= {bus.req_key[119:0], 8'h00};
            r_core_start   <= 1'b1;
            r_core_encrypt <= bus.req_encrypt;
            r_core_idle    <= 1'b0;
            r_req_ready    <= 1'b0;
            r_err_ooo      <= 1'b0;
            r_exp          <= '0;
            r_k            <= '0;
`ifdef AES_HOST_TIMEOUT_EN
            r_err_to       <= 1'b0;
`endif
            r_state        <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_core_start <= 1'b0;
          if (r_k == 4'd15) begin
            r_core_data <= '0;
            r_core_key  <= '0;
`ifdef AES_HOST_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
            r_state     <= S_WAIT;
          end else begin
            r_core_data <= r_blk[127:120];
            r_core_key  <= r_key[127:120];
            r_blk       <= {r_blk[119:0], 8'h00};
            r_key       <= {r_key[119:0], 8'h00};
            r_k         <= r_k + 4'd1;
          end
        end

        S_WAIT: begin
          if (bus.core_out_valid) begin
            for (int i = 0; i < 16; i++) begin
              if (bus.core_out_byte_num == 4'(i)) begin
                r_res[8*(15-i) +: 8] <= bus.core_data_out;
              end
            end
            if (bus.core_out_byte_num != r_exp) begin
              r_err_ooo <= 1'b1;
            end
            // Resynchronise to the core's sequence so one swap is not reported on every later byte.
            r_exp <= bus.core_out_byte_num + 4'd1;
`ifdef AES_HOST_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
            if (bus.core_out_byte_num == 4'd15) begin
              r_res_valid <= 1'b1;
              r_core_idle <= 1'b1;
              r_state     <= S_DONE;
            end
          end
`ifdef AES_HOST_TIMEOUT_EN
          else if (r_to_cnt == TO_LIM - 16'd1) begin
            // Counter would reach the limit this edge: abort with whatever has been collected.
            r_err_to    <= 1'b1;
            r_res_valid <= 1'b1;
            r_core_idle <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
`endif
        end

        S_DONE: begin
          if (r_res_valid && bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_host_bridge.sv
// tb_aes_host_bridge: directed bench for aes_host_bridge with a scripted core model.
// Ports: none. Drives the interface directly; DUT built with TIMEOUT_CYCLES=32.
// Covers reset, serialization timing, in-order and swapped results, hold/backpressure,
// partial results (timeout or indefinite wait) and reset in the middle of LOAD.
module tb_aes_host_bridge;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_host_bridge_if bus();

  aes_host_bridge #(.TIMEOUT_CYCLES(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] pt  = 128'h00112233445566778899AABBCCDDEEFF;
  logic [127:0] key = 128'h000102030405060708090A0B0C0D0E0F;
  logic [127:0] ct  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  logic [127:0] d2  = 128'hFEDCBA98765432100123456789ABCDEF;
  logic [127:0] k2  = 128'h0F0E0D0C0B0A09080706050403020100;
  logic [127:0] exp2;
  logic [127:0] exp3;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [3:0] idx, input logic [7:0] val);
    bus.core_out_valid    = 1'b1;
    bus.core_out_byte_num = idx;
    bus.core_data_out     = val;
    tick();
    bus.core_out_valid    = 1'b0;
    bus.core_out_byte_num = '0;
    bus.core_data_out     = '0;
  endtask

  // Presents a request, lets it be accepted, then checks all 16 LOAD cycles. A stray
  // index-15 byte is offered mid-LOAD; it must not be captured. Ends in WAIT.
  task automatic do_load(input logic [127:0] d, input logic [127:0] k, input logic enc);
    bus.req_data    = d;
    bus.req_key     = k;
    bus.req_encrypt = enc;
    bus.req_valid   = 1'b1;
    tick();
    bus.req_valid   = 1'b0;
    bus.req_data    = '0;
    bus.req_key     = '0;
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("ld_data%0d", i), bus.core_data, d[8*(15-i) +: 8]);
      check_eq($sformatf("ld_key%0d", i), bus.core_key, k[8*(15-i) +: 8]);
      check_eq($sformatf("ld_start%0d", i), bus.core_start, (i == 0));
      check_eq($sformatf("ld_enc%0d", i), bus.core_encrypt, enc);
      check_eq($sformatf("ld_idle%0d", i), bus.core_idle, 1'b0);
      check_eq($sformatf("ld_rdy%0d", i), bus.req_ready, 1'b0);
      if (i == 8) begin
        bus.core_out_valid    = 1'b1;
        bus.core_out_byte_num = 4'd15;
        bus.core_data_out     = 8'hEE;
      end
      tick();
      bus.core_out_valid    = 1'b0;
      bus.core_out_byte_num = '0;
      bus.core_data_out     = '0;
    end
    check_eq("wait_data", bus.core_data, 8'h00);
    check_eq("wait_key", bus.core_key, 8'h00);
    check_eq("wait_start", bus.core_start, 1'b0);
    check_eq("wait_idle", bus.core_idle, 1'b0);
    check_eq("wait_noval", bus.res_valid, 1'b0);
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check_eq("take_val", bus.res_valid, 1'b0);
    check_eq("take_rdy", bus.req_ready, 1'b1);
  endtask

  initial begin
    bus.req_valid         = 1'b0;
    bus.req_data          = '0;
    bus.req_key           = '0;
    bus.req_encrypt       = 1'b0;
    bus.res_ready         = 1'b0;
    bus.core_out_valid    = 1'b0;
    bus.core_out_byte_num = '0;
    bus.core_data_out     = '0;

    // Reset
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_eq("rst_rdy", bus.req_ready, 1'b1);
    check_eq("rst_val", bus.res_valid, 1'b0);
    check_eq("rst_idle", bus.core_idle, 1'b1);
    check_eq("rst_cdata", bus.core_data, 8'h00);
    check_eq("rst_ckey", bus.core_key, 8'h00);
    check_eq("rst_start", bus.core_start, 1'b0);
    check_eq("rst_enc", bus.core_encrypt, 1'b0);
    check_eq("rst_res", bus.res_data, 128'h0);
    check_eq("rst_err", bus.res_err, 2'b00);

    // Job 1: FIPS-197 vector, result returned in order
    do_load(pt, key, 1'b1);
    for (int i = 0; i < 15; i++) send_byte(4'(i), ct[8*(15-i) +: 8]);
    check_eq("j1_pre_val", bus.res_valid, 1'b0);
    send_byte(4'd15, ct[7:0]);
    check_eq("j1_val", bus.res_valid, 1'b1);
    check_eq("j1_res", bus.res_data, ct);
    check_eq("j1_err", bus.res_err, 2'b00);
    check_eq("j1_idle", bus.core_idle, 1'b1);
    check_eq("j1_rdy", bus.req_ready, 1'b0);

    // Hold the result under backpressure while a request is being offered
    bus.req_data    = ~pt;
    bus.req_key     = ~key;
    bus.req_encrypt = 1'b1;
    bus.req_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("hold_val%0d", i), bus.res_valid, 1'b1);
      check_eq($sformatf("hold_res%0d", i), bus.res_data, ct);
      check_eq($sformatf("hold_rdy%0d", i), bus.req_ready, 1'b0);
    end
    take_result();

    // Job 2: decrypt, result indices 0,1,3,2,4..15
    for (int i = 0; i < 16; i++) exp2[8*(15-i) +: 8] = 8'h30 + 8'(i);
    do_load(d2, k2, 1'b0);
    send_byte(4'd0, exp2[127:120]);
    send_byte(4'd1, exp2[119:112]);
    send_byte(4'd3, exp2[103:96]);
    send_byte(4'd2, exp2[111:104]);
    for (int i = 4; i < 15; i++) send_byte(4'(i), exp2[8*(15-i) +: 8]);
    check_eq("j2_pre_val", bus.res_valid, 1'b0);
    send_byte(4'd15, exp2[7:0]);
    check_eq("j2_val", bus.res_valid, 1'b1);
    check_eq("j2_res", bus.res_data, exp2);
    check_eq("j2_err", bus.res_err, 2'b01);
    take_result();

    // Job 3: only bytes 0..7 arrive; slots 8..15 keep job 2's content
    exp3 = exp2;
    do_load(pt, key, 1'b1);
    for (int i = 0; i < 8; i++) begin
      exp3[8*(15-i) +: 8] = 8'hC0 + 8'(i);
      send_byte(4'(i), 8'hC0 + 8'(i));
    end
`ifdef AES_HOST_TIMEOUT_EN
    repeat (31) tick();
    check_eq("to_early_val", bus.res_valid, 1'b0);
    tick();
    check_eq("to_val", bus.res_valid, 1'b1);
    check_eq("to_err", bus.res_err, 2'b10);
    check_eq("to_res", bus.res_data, exp3);
    check_eq("to_idle", bus.core_idle, 1'b1);
`else
    repeat (100) tick();
    check_eq("stall_val", bus.res_valid, 1'b0);
    check_eq("stall_idle", bus.core_idle, 1'b0);
    check_eq("stall_err", bus.res_err, 2'b00);
    exp3[7:0] = 8'h5A;
    send_byte(4'd15, 8'h5A);
    check_eq("gap_val", bus.res_valid, 1'b1);
    check_eq("gap_err", bus.res_err, 2'b01);
    check_eq("gap_res", bus.res_data, exp3);
`endif
    take_result();

    // Job 4: reset while byte 5 is on the bus
    bus.req_data    = pt;
    bus.req_key     = key;
    bus.req_encrypt = 1'b1;
    bus.req_valid   = 1'b1;
    tick();
    bus.req_valid   = 1'b0;
    repeat (5) tick();
    check_eq("mid_k5", bus.core_data, 8'h55);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_eq("mrst_idle", bus.core_idle, 1'b1);
    check_eq("mrst_rdy", bus.req_ready, 1'b1);
    check_eq("mrst_start", bus.core_start, 1'b0);
    check_eq("mrst_cdata", bus.core_data, 8'h00);
    check_eq("mrst_val", bus.res_valid, 1'b0);
    check_eq("mrst_res", bus.res_data, 128'h0);
    check_eq("mrst_err", bus.res_err, 2'b00);
    tick();
    check_eq("post_rst_rdy", bus.req_ready, 1'b1);
    check_eq("post_rst_idle", bus.core_idle, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
